// File: rtl/cond_pkg.sv
// Condition-code and flag-index constants shared by the condition logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cond_pkg;

   // ARM condition field encodings, Instr[31:28]
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // bit positions inside the {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Evaluates a 4-bit ARM condition field against a {N,Z,C,V} flag vector.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       cond_ok
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   // decode the condition field; NV never executes
   always_comb begin
      cond_ok = 1'b0;
      case (Cond)
         COND_EQ: cond_ok = z;
         COND_NE: cond_ok = ~z;
         COND_CS: cond_ok = c;
         COND_CC: cond_ok = ~c;
         COND_MI: cond_ok = n;
         COND_PL: cond_ok = ~n;
         COND_VS: cond_ok = v;
         COND_VC: cond_ok = ~v;
         COND_HI: cond_ok = c & ~z;
         COND_LS: cond_ok = ~c | z;
         COND_GE: cond_ok = (n == v);
         COND_LT: cond_ok = (n != v);
         COND_GT: cond_ok = ~z & (n == v);
         COND_LE: cond_ok = z | (n != v);
         COND_AL: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Holds the NZCV flag register and gates PC/reg/mem write enables by the condition field.
// Latency: one cycle from instr_valid to out_valid and the gated enables.
// Backpressure: none; accepts one instruction every cycle.
module cond_unit
   import cond_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             instr_valid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             out_valid,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0] squash_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic cond_ok;

   // condition is judged against the registered flags, so a flag-setting
   // instruction sees the pre-write values
   cond_check u_cond_check (
      .Cond    (Cond),
      .Flags   (Flags),
      .cond_ok (cond_ok)
   );

   // flag register, registered enables and saturating statistics counters
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         Flags      <= 4'b0000;
         out_valid  <= 1'b0;
         PCSrc      <= 1'b0;
         RegWrite   <= 1'b0;
         MemWrite   <= 1'b0;
         CondEx     <= 1'b0;
         exec_cnt   <= '0;
         squash_cnt <= '0;
      end else if (instr_valid) begin
         if (FlagW[1] && cond_ok)
            Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
         if (FlagW[0] && cond_ok)
            Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
         out_valid <= 1'b1;
         CondEx    <= cond_ok;
         PCSrc     <= PCS & cond_ok;
         RegWrite  <= RegW & cond_ok & ~NoWrite;
         MemWrite  <= MemW & cond_ok;
         if (cond_ok) begin
            if (exec_cnt != CNT_MAX)
               exec_cnt <= exec_cnt + CNT_W'(1);
         end else begin
            if (squash_cnt != CNT_MAX)
               squash_cnt <= squash_cnt + CNT_W'(1);
         end
      end else begin
         // idle cycle: drop enables, keep CondEx, flags and counts
         out_valid <= 1'b0;
         PCSrc     <= 1'b0;
         RegWrite  <= 1'b0;
         MemWrite  <= 1'b0;
      end
   end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer of the ALU's ALUFlags {N,Z,C,V}: holds the architectural flag register, evaluates the 4-bit ARM condition field of each issued instruction against it, and produces write enables gated by that condition.
- Sits between the main decoder and the register file, memory and PC write ports of the multicycle datapath.
- Registered outputs, with per-instruction executed/squashed statistics counters.

Parameters:
- CNT_W, 8, width of the saturating executed/squashed counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk edge.
- instr_valid  in  1  one instruction presented this cycle; other inputs are qualified by it.
- Cond  in  4  ARM condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU for this instruction.
- FlagW  in  2  [1] = write N,Z; [0] = write C,V.
- PCS  in  1  instruction writes the PC.
- RegW  in  1  instruction writes the register file.
- MemW  in  1  instruction writes memory.
- NoWrite  in  1  suppress register write (CMP/CMN/TST/TEQ).
- out_valid  out  1  registered outputs below correspond to the instruction of the previous cycle.
- PCSrc  out  1  gated PC write.
- RegWrite  out  1  gated register write.
- MemWrite  out  1  gated memory write.
- CondEx  out  1  registered condition result.
- Flags  out  4  current flag register {N,Z,C,V}.
- exec_cnt  out  CNT_W  instructions whose condition passed.
- squash_cnt  out  CNT_W  instructions whose condition failed.

Behaviour:
- Reset (reset_n=0 at an edge): Flags=4'b0000; out_valid, PCSrc, RegWrite, MemWrite and CondEx = 0; both counters = 0. Reset has priority over instr_valid. An instruction presented in a reset cycle is dropped: no flag write and no count.
- cond_ok is combinational from Cond and the current Flags register, never from ALUFlags. Mapping:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: 0 (never executes)
- Edge with instr_valid=1 and reset_n=1:
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1]&cond_ok.
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0]&cond_ok.
  - Unwritten halves hold.
  - out_valid<=1; CondEx<=cond_ok; PCSrc<=PCS&cond_ok; RegWrite<=RegW&cond_ok&~NoWrite; MemWrite<=MemW&cond_ok.
  - exec_cnt increments if cond_ok; otherwise squash_cnt increments. Each saturates at 2^CNT_W-1 and never wraps.
- Edge with instr_valid=0: out_valid, PCSrc, RegWrite and MemWrite <= 0; CondEx, Flags and counters hold.
- Latency: one cycle from instr_valid to out_valid and the gated enables.
- Throughput: one instruction per cycle. Back-to-back instructions see flags written by the preceding instruction, because the register updates at the same edge.
- A failed condition never modifies Flags, regardless of FlagW.
- A flag write and a condition check in the same instruction evaluate against the pre-write Flags.
- Simultaneous saturation of one counter and increment of the other: only the unsaturated counter changes.
- Inputs are don't-care when instr_valid=0; X on them must not propagate into state.

Decomposition:
- Shared package cond_pkg holds:
  - 4-bit condition code constants COND_EQ..COND_NV;
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural combinational sub-module, cond_check: inputs Cond[3:0] and Flags[3:0], output cond_ok. It is reused by any later pipelined control.
- Flag register, output register and counters stay in cond_unit.

Test Plan:
- Reset then idle:
  - Drive reset_n=0 for 2 cycles, then 1 with instr_valid=0.
  - Expect Flags=0, all enables 0, out_valid=0, counters 0.
- CMP then BEQ:
  - Cycle A: Cond=1110, ALUFlags=0100, FlagW=11, RegW=1, NoWrite=1. Expect next cycle Flags=0100, RegWrite=0, CondEx=1.
  - Cycle B, back-to-back: Cond=0000, PCS=1. Expect PCSrc=1, exec_cnt=2.
- Failed condition with FlagW:
  - Flags=0100; present Cond=0001, FlagW=11, ALUFlags=1011, RegW=1, MemW=1.
  - Expect Flags stays 0100, RegWrite=0, MemWrite=0, CondEx=0, squash_cnt+1.
- Partial flag write:
  - Flags=0000; present AL, FlagW=10, ALUFlags=1111. Expect Flags=1100.
  - Then GE (1010) with PCS=1: N=1, V=0, so expect PCSrc=0.
- NV and saturation:
  - Issue 260 instructions with Cond=1111 (CNT_W=8).
  - Expect squash_cnt=255 held and exec_cnt=0; out_valid pulses each cycle.
- Reset mid-stream:
  - Assert reset_n=0 in the same cycle as instr_valid=1, Cond=AL, FlagW=11, ALUFlags=1111.
  - Expect next cycle Flags=0, out_valid=0, counters 0.
